// File: rtl/ctrl_pipe.sv
// Control-word pipeline from decode through ID/EX, EX/MEM and MEM/WB.
// Inserts load-use bubbles, squashes on taken branches and freezes on stall_in.
module ctrl_pipe #(
    parameter int unsigned REG_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_ex_ctrl,
    input  logic [3:0]       id_mem_ctrl,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             stall_in,
    input  logic             mem_cond,
    output logic [2:0]       ex_aluop,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             wb_pc_to_reg,
    output logic [REG_W-1:0] wb_rd,
    output logic             id_hold,
    output logic             flush,
    output logic [CNT_W-1:0] hazard_cnt
);

    typedef struct packed {
        logic             valid;
        logic [4:0]       ex;   // {ALUOP[2:0], MemRead, MemWrite}
        logic [3:0]       mem;  // {RegWrite, MemToReg, PCtoReg, Branch}
        logic [REG_W-1:0] rd;
    } stage_t;

    localparam stage_t Bubble = '0;

    stage_t           idex_q, idex_d;
    stage_t           exmem_q, exmem_d;
    stage_t           memwb_q, memwb_d;
    stage_t           decode_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken;
    logic             hazard;
    logic             rs_match;
    logic             rt_match;

    always_comb begin
        decode_entry = Bubble;
        if (id_valid) begin
            decode_entry.valid = 1'b1;
            decode_entry.ex    = id_ex_ctrl;
            decode_entry.mem   = id_mem_ctrl;
            decode_entry.rd    = id_rd;
        end
    end

    assign rs_match = (idex_q.rd == id_rs);
    assign rt_match = (idex_q.rd == id_rt);
    assign taken    = exmem_q.valid & exmem_q.mem[0] & mem_cond;
    assign hazard   = idex_q.valid & idex_q.ex[1] & id_valid & (rs_match | rt_match);

    // A stall masks the flush so a pending taken branch fires after release.
    assign flush   = ~stall_in & taken;
    assign id_hold = stall_in | (~taken & hazard);

    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        cnt_d   = cnt_q;
        if (stall_in) begin
            idex_d  = idex_q;
        end else if (taken) begin
            memwb_d = exmem_q;
            exmem_d = Bubble;
            idex_d  = Bubble;
        end else if (hazard) begin
            memwb_d = exmem_q;
            exmem_d = idex_q;
            idex_d  = Bubble;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            memwb_d = exmem_q;
            exmem_d = idex_q;
            idex_d  = decode_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= Bubble;
            exmem_q <= Bubble;
            memwb_q <= Bubble;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_aluop      = idex_q.ex[4:2];
    assign mem_read      = exmem_q.ex[1];
    assign mem_write     = exmem_q.ex[0];
    assign wb_reg_write  = memwb_q.mem[3];
    assign wb_mem_to_reg = memwb_q.mem[2];
    assign wb_pc_to_reg  = memwb_q.mem[1];
    assign wb_rd         = memwb_q.rd;
    assign hazard_cnt    = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; a second narrow-counter instance covers saturation.
module tb_ctrl_pipe;

    localparam int unsigned REG_W = 6;
    localparam logic [4:0] ExLoad = 5'b11110;
    localparam logic [3:0] MmLoad = 4'b1100;
    localparam logic [4:0] ExAdd  = 5'b10000;
    localparam logic [3:0] MmAdd  = 4'b1000;
    localparam logic [4:0] ExBr   = 5'b01100;
    localparam logic [3:0] MmBr   = 4'b0001;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_ex_ctrl;
    logic [3:0]       id_mem_ctrl;
    logic [REG_W-1:0] id_rd, id_rs, id_rt;
    logic             stall_in;
    logic             mem_cond;

    logic [2:0]       ex_aluop;
    logic             mem_read, mem_write;
    logic             wb_reg_write, wb_mem_to_reg, wb_pc_to_reg;
    logic [REG_W-1:0] wb_rd;
    logic             id_hold, flush;
    logic [15:0]      hazard_cnt;

    logic [2:0]       s_ex_aluop;
    logic             s_mem_read, s_mem_write;
    logic             s_wb_reg_write, s_wb_mem_to_reg, s_wb_pc_to_reg;
    logic [REG_W-1:0] s_wb_rd;
    logic             s_id_hold, s_flush;
    logic [1:0]       s_hazard_cnt;

    int checks;
    int failures;

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
        .id_mem_ctrl(id_mem_ctrl), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .stall_in(stall_in), .mem_cond(mem_cond), .ex_aluop(ex_aluop),
        .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_pc_to_reg(wb_pc_to_reg), .wb_rd(wb_rd),
        .id_hold(id_hold), .flush(flush), .hazard_cnt(hazard_cnt)
    );

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
        .id_mem_ctrl(id_mem_ctrl), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .stall_in(stall_in), .mem_cond(mem_cond), .ex_aluop(s_ex_aluop),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .wb_reg_write(s_wb_reg_write),
        .wb_mem_to_reg(s_wb_mem_to_reg), .wb_pc_to_reg(s_wb_pc_to_reg), .wb_rd(s_wb_rd),
        .id_hold(s_id_hold), .flush(s_flush), .hazard_cnt(s_hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] ex, input logic [3:0] mm,
                          input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                          input logic [REG_W-1:0] rt);
        id_valid    = v;
        id_ex_ctrl  = ex;
        id_mem_ctrl = mm;
        id_rd       = rd;
        id_rs       = rs;
        id_rt       = rt;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 4'd0, '0, '0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_aluop"}, 32'(ex_aluop), 0);
        chk({tag, "_mrd"},   32'(mem_read), 0);
        chk({tag, "_mwr"},   32'(mem_write), 0);
        chk({tag, "_wbrw"},  32'(wb_reg_write), 0);
        chk({tag, "_wbm2r"}, 32'(wb_mem_to_reg), 0);
        chk({tag, "_wbpc"},  32'(wb_pc_to_reg), 0);
        chk({tag, "_wbrd"},  32'(wb_rd), 0);
        chk({tag, "_hold"},  32'(id_hold), 0);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_cnt"},   32'(hazard_cnt), 0);
        chk({tag, "_scnt"},  32'(s_hazard_cnt), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        stall_in = 1'b0;
        mem_cond = 1'b0;
        idle();
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Latency of a load through all three stages
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        chk("lat_c1_aluop", 32'(ex_aluop), 3'b111);
        chk("lat_c1_mrd", 32'(mem_read), 0);
        idle();
        tick();
        chk("lat_c2_mrd", 32'(mem_read), 1);
        chk("lat_c2_aluop", 32'(ex_aluop), 0);
        chk("lat_c2_wbrw", 32'(wb_reg_write), 0);
        tick();
        chk("lat_c3_wbrw", 32'(wb_reg_write), 1);
        chk("lat_c3_m2r", 32'(wb_mem_to_reg), 1);
        chk("lat_c3_pc", 32'(wb_pc_to_reg), 0);
        chk("lat_c3_rd", 32'(wb_rd), 5);
        chk("lat_c3_mrd", 32'(mem_read), 0);
        tick();
        chk("lat_c4_wbrw", 32'(wb_reg_write), 0);

        // Invalid decode entry loads as a bubble
        set_id(1'b0, 5'b11111, 4'b1111, 6'd9, 6'd0, 6'd0);
        tick();
        chk("inv_aluop", 32'(ex_aluop), 0);
        tick();
        chk("inv_mrd", 32'(mem_read), 0);
        chk("inv_mwr", 32'(mem_write), 0);
        tick();
        chk("inv_wbrd", 32'(wb_rd), 0);
        chk("inv_wbrw", 32'(wb_reg_write), 0);

        // Load-use hazard on rs
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd5, 6'd3);
        #1;
        chk("haz_hold", 32'(id_hold), 1);
        chk("haz_flush", 32'(flush), 0);
        tick();
        chk("haz_cnt", 32'(hazard_cnt), 1);
        chk("haz_bubble", 32'(ex_aluop), 0);
        chk("haz_ld_mem", 32'(mem_read), 1);
        chk("haz_hold_once", 32'(id_hold), 0);
        tick();
        chk("haz_add_ex", 32'(ex_aluop), 3'b100);
        chk("haz_ld_wbrd", 32'(wb_rd), 5);
        idle();
        tick();
        chk("haz_bub_wb", 32'(wb_reg_write), 0);
        tick();
        chk("haz_add_wbrw", 32'(wb_reg_write), 1);
        chk("haz_add_wbrd", 32'(wb_rd), 7);
        chk("haz_add_m2r", 32'(wb_mem_to_reg), 0);

        // No hazard when sources differ
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd6, 6'd6);
        #1;
        chk("nohaz_hold", 32'(id_hold), 0);
        tick();
        chk("nohaz_ex", 32'(ex_aluop), 3'b100);
        chk("nohaz_mrd", 32'(mem_read), 1);
        chk("nohaz_cnt", 32'(hazard_cnt), 1);
        idle();
        tick();
        tick();
        chk("nohaz_wbrd", 32'(wb_rd), 7);

        // Register 0 match on rt still counts
        set_id(1'b1, ExLoad, MmLoad, 6'd0, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd1, 6'd0);
        #1;
        chk("r0_hold", 32'(id_hold), 1);
        tick();
        chk("r0_cnt", 32'(hazard_cnt), 2);
        idle();
        repeat (3) tick();

        // Invalid consumer never hazards
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        set_id(1'b0, ExAdd, MmAdd, 6'd7, 6'd5, 6'd5);
        #1;
        chk("invc_hold", 32'(id_hold), 0);
        tick();
        chk("invc_cnt", 32'(hazard_cnt), 2);
        idle();
        repeat (3) tick();

        // Taken branch squashes two younger instructions
        set_id(1'b1, ExBr, MmBr, 6'd3, 6'd1, 6'd2);
        tick();
        chk("tk_br_ex", 32'(ex_aluop), 3'b011);
        set_id(1'b1, ExAdd, MmAdd, 6'd8, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd9, 6'd1, 6'd2);
        mem_cond = 1'b1;
        #1;
        chk("tk_flush", 32'(flush), 1);
        chk("tk_hold", 32'(id_hold), 0);
        tick();
        chk("tk_wbrd", 32'(wb_rd), 3);
        chk("tk_wbrw", 32'(wb_reg_write), 0);
        chk("tk_sq_ex", 32'(ex_aluop), 0);
        mem_cond = 1'b0;
        idle();
        #1;
        chk("tk_flush_once", 32'(flush), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tk_no_retire", 32'(wb_reg_write), 0);
        end

        // Not-taken branch lets both adds retire
        set_id(1'b1, ExBr, MmBr, 6'd3, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd8, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd9, 6'd1, 6'd2);
        #1;
        chk("nt_flush", 32'(flush), 0);
        tick();
        chk("nt_br_wbrd", 32'(wb_rd), 3);
        idle();
        tick();
        chk("nt_a1_wbrd", 32'(wb_rd), 8);
        chk("nt_a1_wbrw", 32'(wb_reg_write), 1);
        tick();
        chk("nt_a2_wbrd", 32'(wb_rd), 9);
        chk("nt_a2_wbrw", 32'(wb_reg_write), 1);
        repeat (2) tick();

        // Stall with a pending taken branch
        set_id(1'b1, ExBr, MmBr, 6'd3, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd8, 6'd1, 6'd2);
        tick();
        idle();
        stall_in = 1'b1;
        mem_cond = 1'b1;
        #1;
        chk("st_flush", 32'(flush), 0);
        chk("st_hold", 32'(id_hold), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_frz_ex", 32'(ex_aluop), 3'b100);
            chk("st_frz_wbrd", 32'(wb_rd), 0);
            chk("st_frz_wbrw", 32'(wb_reg_write), 0);
            chk("st_flush_lo", 32'(flush), 0);
            chk("st_hold_hi", 32'(id_hold), 1);
        end
        stall_in = 1'b0;
        #1;
        chk("st_rel_flush", 32'(flush), 1);
        chk("st_rel_hold", 32'(id_hold), 0);
        tick();
        chk("st_br_wbrd", 32'(wb_rd), 3);
        chk("st_sq_ex", 32'(ex_aluop), 0);
        mem_cond = 1'b0;
        repeat (2) tick();

        // Hazard held off by stall, counted once on release
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd5, 6'd2);
        stall_in = 1'b1;
        #1;
        chk("sh_hold", 32'(id_hold), 1);
        tick();
        chk("sh_cnt_frz", 32'(hazard_cnt), 2);
        chk("sh_ld_frz", 32'(ex_aluop), 3'b111);
        stall_in = 1'b0;
        tick();
        chk("sh_cnt", 32'(hazard_cnt), 3);
        chk("sh_scnt", 32'(s_hazard_cnt), 3);
        chk("sh_bubble", 32'(ex_aluop), 0);
        tick();
        chk("sh_add_ex", 32'(ex_aluop), 3'b100);
        idle();
        repeat (3) tick();

        // Saturation on the narrow counter, plain counting on the wide one
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
            tick();
            set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd5, 6'd2);
            tick();
            tick();
            chk("sat_scnt", 32'(s_hazard_cnt), 3);
            chk("sat_cnt", 32'(hazard_cnt), 32'(4 + i));
        end
        idle();
        repeat (3) tick();

        // Asynchronous reset with every stage valid
        set_id(1'b1, ExLoad, MmLoad, 6'd5, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd7, 6'd1, 6'd2);
        tick();
        set_id(1'b1, ExAdd, MmAdd, 6'd9, 6'd1, 6'd2);
        tick();
        chk("mr_pre_wbrw", 32'(wb_reg_write), 1);
        chk("mr_pre_ex", 32'(ex_aluop), 3'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        rst_n = 1'b1;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
